tetris_board_engine: RTL and testbench

//  Board-state responder for the Tetris control FSM: owns the COLS x ROWS playfield, executes

---
 rtl/tetris_board_engine.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_tetris_board_engine.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tetris_board_engine.sv
// Playfield owner for the Tetris controller: paint/erase/collision-check/row-clear/wipe
// commands plus a registered renderer read port. Optional lock-out: TETRIS_GAMEOVER_EN.
module tetris_board_engine #(
    parameter int COLS = 10,
    parameter int ROWS = 20,
    parameter int CW   = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [15:0]   piece_mask,
    input  logic [4:0]    piece_x,
    input  logic [5:0]    piece_y,
    input  logic [CW-1:0] piece_color,
    output logic          rsp_valid,
    output logic          rsp_canmove,
    output logic [2:0]    rsp_lines,
    output logic          game_over,
    input  logic [3:0]    rd_col,
    input  logic [4:0]    rd_row,
    output logic [CW-1:0] rd_color
);

    localparam int XW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int YW = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [2:0] OP_PAINT = 3'd0;
    localparam logic [2:0] OP_ERASE = 3'd1;
    localparam logic [2:0] OP_CHECK = 3'd2;
    localparam logic [2:0] OP_CLEAR = 3'd3;
    localparam logic [2:0] OP_WIPE  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_ROWCHK,
        S_SHIFT,
        S_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   board_q [ROWS][COLS];
    logic [CW-1:0]   board_d [ROWS][COLS];
    logic [2:0]      op_q, op_d;
    logic [15:0]     mask_q, mask_d;
    logic [4:0]      px_q, px_d;
    logic [5:0]      py_q, py_d;
    logic [CW-1:0]   color_q, color_d;
    logic [3:0]      idx_q, idx_d;
    logic [YW-1:0]   row_q, row_d;
    logic [YW-1:0]   k_q, k_d;
    logic [2:0]      lines_q, lines_d;
    logic            canmove_q, canmove_d;
    logic            lock_q, lock_d;
    logic            game_over_q, game_over_d;
    logic            rsp_canmove_q, rsp_canmove_d;
    logic [2:0]      rsp_lines_q, rsp_lines_d;
    logic [CW-1:0]   rd_color_q, rd_color_d;

    logic [COLS-1:0] cell_nz [ROWS];
    logic [ROWS-1:0] row_full;

    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
            for (genvar gj = 0; gj < COLS; gj++) begin : g_col
                assign cell_nz[gi][gj] = |board_q[gi][gj];
            end
            assign row_full[gi] = &cell_nz[gi];
        end
    endgenerate

    // Cell addressed by the current scan index, 7-bit signed so negative offsets survive.
    logic [6:0]    cell_x, cell_y;
    logic          x_ok, y_neg, y_ok, in_board, bit_on;
    logic [CW-1:0] cell_val;

    assign cell_x   = {{2{px_q[4]}}, px_q} + {5'd0, idx_q[1:0]};
    assign cell_y   = {py_q[5], py_q} + {5'd0, idx_q[3:2]};
    assign x_ok     = !cell_x[6] && (int'(cell_x) < COLS);
    assign y_neg    = cell_y[6];
    assign y_ok     = !y_neg && (int'(cell_y) < ROWS);
    assign in_board = x_ok && y_ok;
    assign bit_on   = mask_q[idx_q];
    assign cell_val = in_board ? board_q[cell_y[YW-1:0]][cell_x[XW-1:0]] : '0;

    always_comb begin
        state_d       = state_q;
        board_d       = board_q;
        op_d          = op_q;
        mask_d        = mask_q;
        px_d          = px_q;
        py_d          = py_q;
        color_d       = color_q;
        idx_d         = idx_q;
        row_d         = row_q;
        k_d           = k_q;
        lines_d       = lines_q;
        canmove_d     = canmove_q;
        lock_d        = lock_q;
        game_over_d   = game_over_q;
        rsp_canmove_d = rsp_canmove_q;
        rsp_lines_d   = rsp_lines_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d      = cmd_op;
                    mask_d    = piece_mask;
                    px_d      = piece_x;
                    py_d      = piece_y;
                    color_d   = piece_color;
                    idx_d     = 4'd0;
                    canmove_d = 1'b1;
                    lines_d   = 3'd0;
                    row_d     = YW'(ROWS - 1);
                    lock_d    = game_over_q;
                    case (cmd_op)
                        OP_PAINT, OP_ERASE, OP_CHECK: state_d = S_SCAN;
                        OP_CLEAR: begin
                            if (game_over_q) begin
                                rsp_canmove_d = 1'b0;
                                rsp_lines_d   = 3'd0;
                                state_d       = S_RESP;
                            end else begin
                                state_d = S_ROWCHK;
                            end
                        end
                        OP_WIPE: begin
                            for (int r = 0; r < ROWS; r++) begin
                                for (int c = 0; c < COLS; c++) begin
                                    board_d[r][c] = '0;
                                end
                            end
                            game_over_d   = 1'b0;
                            rsp_canmove_d = 1'b0;
                            rsp_lines_d   = 3'd0;
                            state_d       = S_RESP;
                        end
                        default: begin
                            rsp_canmove_d = 1'b0;
                            rsp_lines_d   = 3'd0;
                            state_d       = S_RESP;
                        end
                    endcase
                end
            end

            S_SCAN: begin
                if (bit_on) begin
                    case (op_q)
                        OP_PAINT: begin
                            if (in_board && !lock_q) begin
                                board_d[cell_y[YW-1:0]][cell_x[XW-1:0]] = color_q;
                            end
`ifdef TETRIS_GAMEOVER_EN
                            if (y_neg) begin
                                game_over_d = 1'b1;
                            end
`endif
                        end
                        OP_ERASE: begin
                            if (in_board && !lock_q) begin
                                board_d[cell_y[YW-1:0]][cell_x[XW-1:0]] = '0;
                            end
                        end
                        OP_CHECK: begin
                            // Above the board is legal as long as the column is on the board.
                            if (!x_ok || (!y_neg && !y_ok) || (cell_val != '0)) begin
                                canmove_d = 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
                if (idx_q == 4'd15) begin
                    rsp_canmove_d = (op_q == OP_CHECK) && canmove_d;
                    rsp_lines_d   = 3'd0;
                    state_d       = S_RESP;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end

            S_ROWCHK: begin
                if (row_full[row_q]) begin
                    k_d     = row_q;
                    state_d = S_SHIFT;
                end else if (row_q == '0) begin
                    rsp_canmove_d = 1'b0;
                    rsp_lines_d   = lines_q;
                    state_d       = S_RESP;
                end else begin
                    row_d = row_q - YW'(1);
                end
            end

            S_SHIFT: begin
                // The k=1 step also empties row 0, so a full row r costs r cycles (1 if r=0).
                if (k_q != '0) begin
                    for (int c = 0; c < COLS; c++) begin
                        board_d[k_q][c] = board_q[k_q - YW'(1)][c];
                    end
                end
                if (k_q <= YW'(1)) begin
                    for (int c = 0; c < COLS; c++) begin
                        board_d[0][c] = '0;
                    end
                    lines_d = (lines_q == 3'd7) ? 3'd7 : lines_q + 3'd1;
                    state_d = S_ROWCHK;
                end else begin
                    k_d = k_q - YW'(1);
                end
            end

            S_RESP: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_color_d = '0;
        if ((int'(rd_col) < COLS) && (int'(rd_row) < ROWS)) begin
            rd_color_d = board_q[rd_row][rd_col];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    board_q[r][c] <= '0;
                end
            end
            op_q          <= 3'd0;
            mask_q        <= 16'd0;
            px_q          <= 5'd0;
            py_q          <= 6'd0;
            color_q       <= '0;
            idx_q         <= 4'd0;
            row_q         <= '0;
            k_q           <= '0;
            lines_q       <= 3'd0;
            canmove_q     <= 1'b0;
            lock_q        <= 1'b0;
            game_over_q   <= 1'b0;
            rsp_canmove_q <= 1'b0;
            rsp_lines_q   <= 3'd0;
            rd_color_q    <= '0;
        end else begin
            state_q       <= state_d;
            board_q       <= board_d;
            op_q          <= op_d;
            mask_q        <= mask_d;
            px_q          <= px_d;
            py_q          <= py_d;
            color_q       <= color_d;
            idx_q         <= idx_d;
            row_q         <= row_d;
            k_q           <= k_d;
            lines_q       <= lines_d;
            canmove_q     <= canmove_d;
            lock_q        <= lock_d;
            game_over_q   <= game_over_d;
            rsp_canmove_q <= rsp_canmove_d;
            rsp_lines_q   <= rsp_lines_d;
            rd_color_q    <= rd_color_d;
        end
    end

    assign cmd_ready   = (state_q == S_IDLE);
    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_canmove = rsp_canmove_q;
    assign rsp_lines   = rsp_lines_q;
    assign game_over   = game_over_q;
    assign rd_color    = rd_color_q;

endmodule

// File: tb/tb_tetris_board_engine.sv
// Directed bench for tetris_board_engine: hand-computed board images and responses,
// one line printed per command.
module tb_tetris_board_engine;

    localparam logic [2:0] OP_PAINT = 3'd0;
    localparam logic [2:0] OP_ERASE = 3'd1;
    localparam logic [2:0] OP_CHECK = 3'd2;
    localparam logic [2:0] OP_CLEAR = 3'd3;
    localparam logic [2:0] OP_WIPE  = 3'd4;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [15:0] piece_mask;
    logic [4:0]  piece_x;
    logic [5:0]  piece_y;
    logic [2:0]  piece_color;
    logic        rsp_valid;
    logic        rsp_canmove;
    logic [2:0]  rsp_lines;
    logic        game_over;
    logic [3:0]  rd_col;
    logic [4:0]  rd_row;
    logic [2:0]  rd_color;

    int n_checks;
    int n_errors;
    int lat;
    int last_canmove;
    int last_lines;
    int seen;
    logic [2:0] rc;

    logic [2:0] exp_b [20][10];
    logic [2:0] got_b [20][10];

    tetris_board_engine dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .piece_mask  (piece_mask),
        .piece_x     (piece_x),
        .piece_y     (piece_y),
        .piece_color (piece_color),
        .rsp_valid   (rsp_valid),
        .rsp_canmove (rsp_canmove),
        .rsp_lines   (rsp_lines),
        .game_over   (game_over),
        .rd_col      (rd_col),
        .rd_row      (rd_row),
        .rd_color    (rd_color)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 one cycle after the response pulse.
    task automatic do_cmd(input logic [2:0] op, input logic [15:0] mask, input int x,
                          input int y, input logic [2:0] color, output int latency);
        int n;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        cmd_valid   = 1'b1;
        cmd_op      = op;
        piece_mask  = mask;
        piece_x     = 5'(x);
        piece_y     = 6'(y);
        piece_color = color;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check_eq("busy_ready", {31'd0, cmd_ready}, 32'd0);
        latency = 1;
        while (!rsp_valid && latency < 200) begin
            @(posedge clk); #1; latency++;
        end
        check_eq("rsp_seen", {31'd0, rsp_valid}, 32'd1);
        last_canmove = int'(rsp_canmove);
        last_lines   = int'(rsp_lines);
        $display("cmd op=%0d mask=%h x=%0d y=%0d color=%0d lat=%0d canmove=%0d lines=%0d",
                 op, mask, x, y, color, latency, last_canmove, last_lines);
        @(posedge clk); #1;
        check_eq("rsp_pulse", {31'd0, rsp_valid}, 32'd0);
    endtask

    task automatic read_cell(input int c, input int r, output logic [2:0] color);
        rd_col = 4'(c);
        rd_row = 5'(r);
        @(posedge clk); #1;
        color = rd_color;
    endtask

    task automatic clear_exp();
        for (int r = 0; r < 20; r++)
            for (int c = 0; c < 10; c++)
                exp_b[r][c] = 3'd0;
    endtask

    task automatic compare_board(input string tag);
        int bad;
        logic [2:0] v;
        bad = 0;
        for (int r = 0; r < 20; r++) begin
            for (int c = 0; c < 10; c++) begin
                read_cell(c, r, v);
                got_b[r][c] = v;
                if (got_b[r][c] !== exp_b[r][c]) bad++;
            end
        end
        check_eq(tag, bad, 0);
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        reset       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_op      = 3'd0;
        piece_mask  = 16'd0;
        piece_x     = 5'd0;
        piece_y     = 6'd0;
        piece_color = 3'd0;
        rd_col      = 4'd0;
        rd_row      = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_canmove", {31'd0, rsp_canmove}, 32'd0);
        check_eq("rst_lines", {29'd0, rsp_lines}, 32'd0);
        check_eq("rst_game_over", {31'd0, game_over}, 32'd0);
        check_eq("rst_rd_color", {29'd0, rd_color}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        clear_exp();
        compare_board("rst_board");

        // 2x2 block at the bottom.
        do_cmd(OP_PAINT, 16'h0033, 4, 18, 3'd5, lat);
        check_eq("paint_latency", lat, 17);
        exp_b[18][4] = 3'd5; exp_b[18][5] = 3'd5;
        exp_b[19][4] = 3'd5; exp_b[19][5] = 3'd5;
        compare_board("paint_board");
        read_cell(4, 19, rc);
        check_eq("rd_in_range", {29'd0, rc}, 32'd5);
        read_cell(10, 19, rc);
        check_eq("rd_col_oor", {29'd0, rc}, 32'd0);
        read_cell(4, 20, rc);
        check_eq("rd_row_oor", {29'd0, rc}, 32'd0);

        // Collision checks.
        do_cmd(OP_CHECK, 16'h0033, 4, 17, 3'd0, lat);
        check_eq("check_latency", lat, 17);
        check_eq("chk_overlap", last_canmove, 0);
        do_cmd(OP_CHECK, 16'h0033, 8, 0, 3'd0, lat);
        check_eq("chk_free", last_canmove, 1);
        do_cmd(OP_CHECK, 16'h0033, 9, 0, 3'd0, lat);
        check_eq("chk_right_wall", last_canmove, 0);
        do_cmd(OP_CHECK, 16'h0033, 0, -2, 3'd0, lat);
        check_eq("chk_above_top", last_canmove, 1);
        do_cmd(OP_CHECK, 16'h0002, -1, 5, 3'd0, lat);
        check_eq("chk_neg_x_unset", last_canmove, 1);
        do_cmd(OP_CHECK, 16'h0001, -1, 5, 3'd0, lat);
        check_eq("chk_left_wall", last_canmove, 0);
        do_cmd(OP_CHECK, 16'h0011, 0, 19, 3'd0, lat);
        check_eq("chk_floor", last_canmove, 0);

        // Row 19 and 17 full, row 18 missing col 9, markers in rows 16 and 0.
        do_cmd(OP_PAINT, 16'h000F, 0, 19, 3'd1, lat);
        do_cmd(OP_PAINT, 16'h000F, 6, 19, 3'd1, lat);
        do_cmd(OP_PAINT, 16'h000F, 0, 18, 3'd2, lat);
        do_cmd(OP_PAINT, 16'h0007, 6, 18, 3'd2, lat);
        do_cmd(OP_PAINT, 16'h000F, 0, 17, 3'd3, lat);
        do_cmd(OP_PAINT, 16'h0003, 4, 17, 3'd3, lat);
        do_cmd(OP_PAINT, 16'h000F, 6, 17, 3'd3, lat);
        do_cmd(OP_PAINT, 16'h0001, 0, 16, 3'd6, lat);
        do_cmd(OP_PAINT, 16'h0001, 2, 0, 3'd7, lat);
        for (int c = 0; c < 10; c++) begin
            exp_b[17][c] = 3'd3;
            exp_b[19][c] = (c == 4 || c == 5) ? 3'd5 : 3'd1;
            exp_b[18][c] = (c == 4 || c == 5) ? 3'd5 : ((c == 9) ? 3'd0 : 3'd2);
        end
        exp_b[16][0] = 3'd6;
        exp_b[0][2]  = 3'd7;
        compare_board("pre_clear_board");

        do_cmd(OP_CLEAR, 16'h0000, 0, 0, 3'd0, lat);
        check_eq("clear_lines", last_lines, 2);
        clear_exp();
        for (int c = 0; c < 10; c++)
            exp_b[19][c] = (c == 4 || c == 5) ? 3'd5 : ((c == 9) ? 3'd0 : 3'd2);
        exp_b[18][0] = 3'd6;
        exp_b[2][2]  = 3'd7;
        compare_board("post_clear_board");

        do_cmd(OP_CLEAR, 16'h0000, 0, 0, 3'd0, lat);
        check_eq("clear_none", last_lines, 0);

        // Empty mask is always legal; response fields hold after the pulse.
        do_cmd(OP_CHECK, 16'h0000, 9, 19, 3'd0, lat);
        check_eq("chk_empty_mask", last_canmove, 1);
        repeat (3) @(posedge clk);
        #1;
        check_eq("rsp_hold", {31'd0, rsp_canmove}, 32'd1);

        // Reserved opcode.
        do_cmd(3'd6, 16'hFFFF, 0, 0, 3'd7, lat);
        check_eq("rsvd_latency", lat, 1);
        check_eq("rsvd_canmove", last_canmove, 0);
        check_eq("rsvd_lines", last_lines, 0);
        compare_board("rsvd_board");

        // ERASE of the two marker cells.
        do_cmd(OP_ERASE, 16'h0001, 0, 18, 3'd0, lat);
        do_cmd(OP_ERASE, 16'h0001, 2, 2, 3'd0, lat);
        exp_b[18][0] = 3'd0;
        exp_b[2][2]  = 3'd0;
        compare_board("erase_board");

        // Reset in the middle of a scan.
        cmd_valid   = 1'b1;
        cmd_op      = OP_PAINT;
        piece_mask  = 16'hFFFF;
        piece_x     = 5'd0;
        piece_y     = 6'd0;
        piece_color = 3'd1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_eq("scan_busy", {31'd0, cmd_ready}, 32'd0);
        reset = 1'b1;
        #1;
        check_eq("abort_ready", {31'd0, cmd_ready}, 32'd1);
        check_eq("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("abort_rd_color", {29'd0, rd_color}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        check_eq("abort_no_rsp", seen, 0);
        check_eq("abort_ready_after", {31'd0, cmd_ready}, 32'd1);
        clear_exp();
        compare_board("abort_board");

`ifdef TETRIS_GAMEOVER_EN
        do_cmd(OP_PAINT, 16'h0011, 3, -1, 3'd4, lat);
        check_eq("go_set", {31'd0, game_over}, 32'd1);
        do_cmd(OP_PAINT, 16'h0001, 0, 5, 3'd1, lat);
        read_cell(0, 5, rc);
        check_eq("go_paint_blocked", {29'd0, rc}, 32'd0);
        check_eq("go_sticky", {31'd0, game_over}, 32'd1);
        do_cmd(OP_CLEAR, 16'h0000, 0, 0, 3'd0, lat);
        check_eq("go_clear_lines", last_lines, 0);
        do_cmd(OP_WIPE, 16'h0000, 0, 0, 3'd0, lat);
        check_eq("wipe_latency", lat, 1);
        check_eq("go_cleared", {31'd0, game_over}, 32'd0);
        clear_exp();
        compare_board("wipe_board");
`else
        do_cmd(OP_PAINT, 16'h0011, 3, -1, 3'd4, lat);
        check_eq("go_tied", {31'd0, game_over}, 32'd0);
        exp_b[0][3] = 3'd4;
        compare_board("neg_y_paint_board");
        do_cmd(OP_WIPE, 16'h0000, 0, 0, 3'd0, lat);
        check_eq("wipe_latency", lat, 1);
        clear_exp();
        compare_board("wipe_board");
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
